// File: rtl/aemb2_sparam_tpsram.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_sparam_tpsram
// Purpose  : Combined RAM block for the AEMB2 core.
//            S RAM : single-port RAM. Write is synchronous. Read is asynchronous.
//            T RAM : true two-port RAM (ports A and X). Both ports use
//                    synchronous read-before-write with 1-cycle latency.
//                    When both ports write the same address on one edge,
//                    port A's data is stored.
// Ports    : gclk                       - sole clock, rising edge
//            grst                       - synchronous active-high reset;
//                                         clears a_dat_o/x_dat_o only
//            s_adr_i/s_dat_i/s_wre_i/s_ena_i/s_dat_o  - S RAM port
//            a_adr_i/a_dat_i/a_wre_i/a_ena_i/a_dat_o  - T RAM port A
//            x_adr_i/x_dat_i/x_wre_i/x_ena_i/x_dat_o  - T RAM port X
// Config   : AEMB2_RAM_ZERO_INIT_EN - when defined, every location of both
//            RAMs starts at zero. When undefined, no initialisation is done.
// Revision : 1.0 - initial release
// ============================================================================
module aemb2_sparam_tpsram #(
   parameter int S_AW = 5,
   parameter int S_DW = 37,
   parameter int T_AW = 9,
   parameter int T_DW = 32
) (
   input  logic            gclk,
   input  logic            grst,
   // single-port RAM
   input  logic [S_AW-1:0] s_adr_i,
   input  logic [S_DW-1:0] s_dat_i,
   input  logic            s_wre_i,
   input  logic            s_ena_i,
   output logic [S_DW-1:0] s_dat_o,
   // two-port RAM, port A
   input  logic [T_AW-1:0] a_adr_i,
   input  logic [T_DW-1:0] a_dat_i,
   input  logic            a_wre_i,
   input  logic            a_ena_i,
   output logic [T_DW-1:0] a_dat_o,
   // two-port RAM, port X
   input  logic [T_AW-1:0] x_adr_i,
   input  logic [T_DW-1:0] x_dat_i,
   input  logic            x_wre_i,
   input  logic            x_ena_i,
   output logic [T_DW-1:0] x_dat_o
);

   localparam int C_SDEPTH = 1 << S_AW;
   localparam int C_TDEPTH = 1 << T_AW;

   logic [S_DW-1:0] r_memS [0:C_SDEPTH-1];
   logic [T_DW-1:0] r_memT [0:C_TDEPTH-1];
   logic [T_DW-1:0] r_aDat;
   logic [T_DW-1:0] r_xDat;

`ifdef AEMB2_RAM_ZERO_INIT_EN
   // Time-zero contents only. This block is never a reset path.
   initial begin
      for (int i = 0; i < C_SDEPTH; i++) r_memS[i] <= '0;
      for (int i = 0; i < C_TDEPTH; i++) r_memT[i] <= '0;
   end
`else
   // No initialisation. Unwritten locations read as unknown.
`endif

   // ------------------------------------------------------------------------
   // S RAM: synchronous write, asynchronous read.
   // ------------------------------------------------------------------------
   always_ff @(posedge gclk) begin
      if (s_ena_i && s_wre_i) r_memS[s_adr_i] <= s_dat_i;
   end

   assign s_dat_o = r_memS[s_adr_i];

   // ------------------------------------------------------------------------
   // T RAM: both ports are handled in one process. Reads sample the array
   // before any of this edge's non-blocking writes land, which gives
   // read-before-write on each port and across the two ports.
   // Port X writes first and port A writes last, so port A wins when both
   // ports write the same address. grst clears only the output registers.
   // Writes that are requested on a reset edge still take place.
   // ------------------------------------------------------------------------
   always_ff @(posedge gclk) begin
      if (grst) begin
         r_aDat <= '0;
         r_xDat <= '0;
      end else begin
         if (a_ena_i) r_aDat <= r_memT[a_adr_i];
         if (x_ena_i) r_xDat <= r_memT[x_adr_i];
      end
      if (x_ena_i && x_wre_i) r_memT[x_adr_i] <= x_dat_i;
      if (a_ena_i && a_wre_i) r_memT[a_adr_i] <= a_dat_i;
   end

   assign a_dat_o = r_aDat;
   assign x_dat_o = r_xDat;

endmodule
`default_nettype wire

// File: tb/tb_aemb2_sparam_tpsram.sv
`default_nettype none
// ============================================================================
// Module   : tb_aemb2_sparam_tpsram
// Purpose  : Directed self-checking bench for aemb2_sparam_tpsram.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aemb2_sparam_tpsram;

   logic        gclk = 1'b0;
   logic        grst;
   logic [4:0]  s_adr_i;
   logic [36:0] s_dat_i;
   logic        s_wre_i, s_ena_i;
   logic [36:0] s_dat_o;
   logic [8:0]  a_adr_i, x_adr_i;
   logic [31:0] a_dat_i, x_dat_i;
   logic        a_wre_i, a_ena_i, x_wre_i, x_ena_i;
   logic [31:0] a_dat_o, x_dat_o;

   int nCmp = 0;
   int nErr = 0;

   aemb2_sparam_tpsram dut (
      .gclk    (gclk),
      .grst    (grst),
      .s_adr_i (s_adr_i),
      .s_dat_i (s_dat_i),
      .s_wre_i (s_wre_i),
      .s_ena_i (s_ena_i),
      .s_dat_o (s_dat_o),
      .a_adr_i (a_adr_i),
      .a_dat_i (a_dat_i),
      .a_wre_i (a_wre_i),
      .a_ena_i (a_ena_i),
      .a_dat_o (a_dat_o),
      .x_adr_i (x_adr_i),
      .x_dat_i (x_dat_i),
      .x_wre_i (x_wre_i),
      .x_ena_i (x_ena_i),
      .x_dat_o (x_dat_o)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge. Outputs settle 1 time unit after the rising edge.
   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   initial begin
      grst = 1'b1;
      s_adr_i = '0; s_dat_i = '0; s_wre_i = 1'b0; s_ena_i = 1'b0;
      a_adr_i = '0; a_dat_i = '0; a_wre_i = 1'b0; a_ena_i = 1'b0;
      x_adr_i = '0; x_dat_i = '0; x_wre_i = 1'b0; x_ena_i = 1'b0;
      tick();
      chk("rst_a", 64'(a_dat_o), 64'h0);
      chk("rst_x", 64'(x_dat_o), 64'h0);
      grst = 1'b0;

      // S RAM: write, then an immediate asynchronous read
      s_ena_i = 1'b1; s_wre_i = 1'b1; s_adr_i = 5'd3; s_dat_i = 37'h1_2345_6789;
      tick();
      s_wre_i = 1'b0;
      #1 chk("s_rd3", 64'(s_dat_o), 64'h1_2345_6789);
      // a disabled port does not write
      s_ena_i = 1'b0; s_wre_i = 1'b1; s_dat_i = 37'h0_ABCD_EF01;
      tick();
      chk("s_gate", 64'(s_dat_o), 64'h1_2345_6789);
      // the two end addresses are independent
      s_ena_i = 1'b1; s_adr_i = 5'd0;  s_dat_i = 37'h1_F00D_0000; tick();
      s_adr_i = 5'd31; s_dat_i = 37'h0_0000_5555; tick();
      s_wre_i = 1'b0;
      s_adr_i = 5'd0;  #1 chk("s_rd0",  64'(s_dat_o), 64'h1_F00D_0000);
      s_adr_i = 5'd31; #1 chk("s_rd31", 64'(s_dat_o), 64'h0_0000_5555);
      s_adr_i = 5'd3;  #1 chk("s_rd3b", 64'(s_dat_o), 64'h1_2345_6789);

      // port A writes 0x1FF, then port X reads it
      a_ena_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 9'h1FF; a_dat_i = 32'hDEADBEEF;
      tick();
      a_ena_i = 1'b0; a_wre_i = 1'b0;
      x_ena_i = 1'b1; x_adr_i = 9'h1FF;
      tick();
      chk("x_rd1ff", 64'(x_dat_o), 64'hDEADBEEF);
      // port X writes address 0, then port A reads 0x1FF
      x_wre_i = 1'b1; x_adr_i = 9'h000; x_dat_i = 32'h12121212;
      tick();
      x_wre_i = 1'b0; x_ena_i = 1'b0;
      a_ena_i = 1'b1; a_adr_i = 9'h1FF;
      tick();
      chk("a_rd1ff", 64'(a_dat_o), 64'hDEADBEEF);
      a_adr_i = 9'h000;
      tick();
      chk("a_rd0", 64'(a_dat_o), 64'h12121212);
      // read-before-write on the same port
      a_adr_i = 9'h1FF; a_wre_i = 1'b1; a_dat_i = 32'hCAFEF00D;
      tick();
      chk("a_rbw_old", 64'(a_dat_o), 64'hDEADBEEF);
      a_wre_i = 1'b0;
      tick();
      chk("a_rbw_new", 64'(a_dat_o), 64'hCAFEF00D);

      // cross-port collision: A writes 7 while X reads 7 on the same edge
      a_adr_i = 9'd7; a_wre_i = 1'b1; a_dat_i = 32'h77777777;
      tick();
      a_dat_i = 32'hAAAA5555;
      x_ena_i = 1'b1; x_adr_i = 9'd7;
      tick();
      chk("coll_old", 64'(x_dat_o), 64'h77777777);
      a_ena_i = 1'b0; a_wre_i = 1'b0;
      tick();
      chk("coll_new", 64'(x_dat_o), 64'hAAAA5555);

      // both ports write address 9: port A data is stored
      a_ena_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 9'd9; a_dat_i = 32'h11111111;
      x_ena_i = 1'b1; x_wre_i = 1'b1; x_adr_i = 9'd9; x_dat_i = 32'h22222222;
      tick();
      a_ena_i = 1'b0; a_wre_i = 1'b0; x_wre_i = 1'b0;
      tick();
      chk("dual_wr", 64'(x_dat_o), 64'h11111111);

      // reset clears the outputs. Memory is kept, and a write on the reset edge still happens.
      a_ena_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 9'd5; a_dat_i = 32'h55AA55AA;
      tick();
      grst = 1'b1;
      a_adr_i = 9'd6; a_dat_i = 32'h66666666;
      x_adr_i = 9'd5;
      tick();
      chk("rst2_x", 64'(x_dat_o), 64'h0);
      chk("rst2_a", 64'(a_dat_o), 64'h0);
      grst = 1'b0; a_wre_i = 1'b0;
      tick();
      chk("post_rst_x5", 64'(x_dat_o), 64'h55AA55AA);
      chk("post_rst_a6", 64'(a_dat_o), 64'h66666666);
      a_ena_i = 1'b0;

`ifndef AEMB2_RAM_ZERO_INIT_EN
      // without zero-init, give 0x100 a known zero first
      a_ena_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 9'h100; a_dat_i = 32'h0;
      tick();
      a_ena_i = 1'b0; a_wre_i = 1'b0;
`endif
      x_ena_i = 1'b1; x_adr_i = 9'h100;
      tick();
      chk("x_rd100", 64'(x_dat_o), 64'h0);
      // a disabled port holds its output and does not write
      x_ena_i = 1'b0; x_wre_i = 1'b1; x_adr_i = 9'd9; x_dat_i = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("x_hold%0d", i), 64'(x_dat_o), 64'h0);
      end
      x_ena_i = 1'b1; x_wre_i = 1'b0;
      tick();
      chk("x_nowr9", 64'(x_dat_o), 64'h11111111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
`default_nettype wire
